lsu_byte: RTL and testbench

Load/store unit that acts as the initiator for the core's dual-port byte-wide data RAM. It accepts one RISC-V load or store request at a time and decomposes it into byte transactions on the RAM's two ports, two bytes per cycle. For loads it reassembles, sign- or zero-extends and returns the 32-bit result. It sits between the execute/memory stage and the data RAM.

---
 rtl/lsu_byte_pkg.sv | 40 ++++
 rtl/lsu_byte_if.sv | 22 ++
 rtl/lsu_byte_load_ext.sv | 29 ++
 rtl/lsu_byte.sv | 175 +++++++++++++++++
 tb/tb_lsu_byte.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_byte_pkg.sv
// Shared types for the byte-wide load/store unit: funct3 codes, access size, FSM states.
// The FLT state exists only when MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH0  = 3'd1,
    ST_PH1  = 3'd2,
    ST_FIN  = 3'd3
`ifdef MISALIGN_TRAP_EN
    , ST_FLT = 3'd4
`endif
  } state_e;

  // Reserved encodings 011/110/111 fall through to a word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_byte_if.sv
// Request/response handshake between the memory stage (master) and the LSU (slave).
interface lsu_byte_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/lsu_byte_load_ext.sv
// Combinational load extender: picks 1, 2 or 4 little-endian bytes and sign/zero-extends.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] i_bytes,
  input  size_e       i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic w_sign;

  always_comb begin
    w_sign = 1'b0;
    o_data = i_bytes;
    case (i_size)
      SZ_B: begin
        w_sign = i_bytes[7] & ~i_unsigned;
        o_data = {{24{w_sign}}, i_bytes[7:0]};
      end
      SZ_H: begin
        w_sign = i_bytes[15] & ~i_unsigned;
        o_data = {{16{w_sign}}, i_bytes[15:0]};
      end
      default: o_data = i_bytes;
    endcase
  end

endmodule

// File: rtl/lsu_byte.sv
// Byte-wide dual-port RAM initiator: splits one load/store into two bytes per cycle.
// Optional MISALIGN_TRAP_EN faults misaligned H/HU/W accesses instead of performing them.
module lsu_byte
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_BITS = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_byte_if.slave   bus,
  output logic        ram_we1,
  output logic        ram_we2,
  output logic [31:0] ram_rw_num1,
  output logic [31:0] ram_rw_num2,
  output logic [7:0]  ram_w_data1,
  output logic [7:0]  ram_w_data2,
  input  logic [7:0]  ram_r_data1,
  input  logic [7:0]  ram_r_data2
);

  localparam logic [31:0] IDX_MASK =
    (ADDR_BITS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADDR_BITS) - 32'd1);

  function automatic logic [31:0] idx(input logic [31:0] a, input logic [1:0] k);
    return (a + {30'b0, k}) & IDX_MASK;
  endfunction

  state_e      r_state;
  logic        r_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  size_e       r_size;
  logic        r_uns;
  logic [7:0]  r_b0;
  logic [7:0]  r_b1;

  logic        w_take;
  logic [31:0] w_bytes;
  logic [31:0] w_ext;

  assign w_take = bus.req_valid && r_ready && (r_state == ST_IDLE);

`ifdef MISALIGN_TRAP_EN
  logic r_resp_fault;
  logic w_misalign;
  size_e w_req_size;

  assign w_req_size = f3_size(bus.req_funct3);
  assign w_misalign = ((w_req_size == SZ_H) && bus.req_addr[0]) ||
                      ((w_req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
  assign bus.resp_fault = r_resp_fault;
`else
  assign bus.resp_fault = 1'b0;
`endif

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;

  // Control FSM with registered handshake/response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      r_resp_fault <= 1'b0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_ready <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            if (w_misalign) r_state <= ST_FLT;
            else            r_state <= ST_PH0;
`else
            r_state <= ST_PH0;
`endif
          end
        end
        ST_PH0: r_state <= (r_size == SZ_W) ? ST_PH1 : ST_FIN;
        ST_PH1: r_state <= ST_FIN;
        ST_FIN: begin
          r_state      <= ST_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_we ? 32'h0 : w_ext;
`ifdef MISALIGN_TRAP_EN
          r_resp_fault <= 1'b0;
`endif
        end
`ifdef MISALIGN_TRAP_EN
        ST_FLT: begin
          r_state      <= ST_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= 32'h0;
          r_resp_fault <= 1'b1;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Request latch and capture of the PH0 read bytes (they arrive during PH1)
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_addr  <= (bus.req_addr - BASE_ADDR) & IDX_MASK;
      r_wdata <= bus.req_wdata;
      r_we    <= bus.req_we;
      r_size  <= f3_size(bus.req_funct3);
      r_uns   <= f3_unsigned(bus.req_funct3);
    end
    if (r_state == ST_PH1) begin
      r_b0 <= ram_r_data1;
      r_b1 <= ram_r_data2;
    end
  end

  // In FIN the RAM is returning the last phase's bytes on the read ports
  always_comb begin
    if (r_size == SZ_W) w_bytes = {ram_r_data2, ram_r_data1, r_b1, r_b0};
    else                w_bytes = {16'h0, ram_r_data2, ram_r_data1};
  end

  lsu_load_ext u_ext (
    .i_bytes    (w_bytes),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ext)
  );

  always_comb begin
    ram_we1     = 1'b0;
    ram_we2     = 1'b0;
    ram_rw_num1 = 32'h0;
    ram_rw_num2 = 32'h0;
    ram_w_data1 = 8'h0;
    ram_w_data2 = 8'h0;
    case (r_state)
      ST_PH0: begin
        ram_we1     = r_we;
        ram_rw_num1 = idx(r_addr, 2'd0);
        ram_w_data1 = r_wdata[7:0];
        if (r_size != SZ_B) begin
          ram_we2     = r_we;
          ram_rw_num2 = idx(r_addr, 2'd1);
          ram_w_data2 = r_wdata[15:8];
        end
      end
      ST_PH1: begin
        ram_we1     = r_we;
        ram_rw_num1 = idx(r_addr, 2'd2);
        ram_w_data1 = r_wdata[23:16];
        ram_we2     = r_we;
        ram_rw_num2 = idx(r_addr, 2'd3);
        ram_w_data2 = r_wdata[31:24];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_byte.sv
// Scoreboard bench for lsu_byte with a behavioural 1-cycle-latency dual-port byte RAM.
module tb_lsu_byte;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lsu_byte_if bus ();

  logic        we1, we2;
  logic [31:0] n1, n2;
  logic [7:0]  wd1, wd2;
  logic [7:0]  rd1, rd2;

  lsu_byte #(.BASE_ADDR(32'h0000_0000), .ADDR_BITS(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ram_we1     (we1),
    .ram_we2     (we2),
    .ram_rw_num1 (n1),
    .ram_rw_num2 (n2),
    .ram_w_data1 (wd1),
    .ram_w_data2 (wd2),
    .ram_r_data1 (rd1),
    .ram_r_data2 (rd2)
  );

  logic [7:0] mem [32768] = '{default: 8'h00};
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_acc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] fault;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] s_we1 [4096];
  logic [31:0] s_we2 [4096];
  logic [31:0] s_n1  [4096];
  logic [31:0] s_n2  [4096];
  logic [31:0] s_wd1 [4096];
  logic [31:0] s_wd2 [4096];

  always @(posedge clk) begin
    if (we1) mem[n1[14:0]] <= wd1;
    if (we2) mem[n2[14:0]] <= wd2;
    rd1 <= mem[n1[14:0]];
    rd2 <= mem[n2[14:0]];
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int k;
    k = cyc & 4095;
    s_we1[k] = 32'(we1);
    s_we2[k] = 32'(we2);
    s_n1[k]  = n1;
    s_n2[k]  = n2;
    s_wd1[k] = 32'(wd1);
    s_wd2[k] = 32'(wd2);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      exp_t e;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: actual resp_valid=1 rdata 0x%08h, required no response",
                 bus.resp_rdata);
      end else begin
        e = sbq.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_fault", 32'(bus.resp_fault), e.fault);
        chk("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_f,
                       input int lat, input bit busy);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: actual req_ready=0 after %0d cycles, required 1", w);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    sbq.push_back('{exp_rd, 32'(exp_f), cyc + 1, lat});
    last_acc = cyc + 1;
    @(negedge clk);
    if (busy) begin
      bus.req_addr   = 32'h40;
      bus.req_funct3 = F3_W;
      bus.req_we     = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual %0d responses outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    int a;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready",  32'(bus.req_ready), 32'd1);
    chk("rst_we1",    32'(we1), 32'd0);
    chk("rst_we2",    32'(we2), 32'd0);
    chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata",  bus.resp_rdata, 32'd0);
    chk("rst_fault",  32'(bus.resp_fault), 32'd0);
    chk("rst_num1",   n1, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready",  32'(bus.req_ready), 32'd1);
    chk("rel_we1",    32'(we1), 32'd0);
    chk("rel_rvalid", 32'(bus.resp_valid), 32'd0);

    // SW 0x10
    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b0);
    a = last_acc;
    drain();
    chk("sw_ph0_we1", s_we1[a & 4095], 32'd1);
    chk("sw_ph0_n1",  s_n1[a & 4095],  32'h10);
    chk("sw_ph0_d1",  s_wd1[a & 4095], 32'hEF);
    chk("sw_ph0_we2", s_we2[a & 4095], 32'd1);
    chk("sw_ph0_n2",  s_n2[a & 4095],  32'h11);
    chk("sw_ph0_d2",  s_wd2[a & 4095], 32'hBE);
    chk("sw_ph1_n1",  s_n1[(a + 1) & 4095],  32'h12);
    chk("sw_ph1_d1",  s_wd1[(a + 1) & 4095], 32'hAD);
    chk("sw_ph1_n2",  s_n2[(a + 1) & 4095],  32'h13);
    chk("sw_ph1_d2",  s_wd2[(a + 1) & 4095], 32'hDE);
    chk("sw_fin_we1", s_we1[(a + 2) & 4095], 32'd0);
    chk("sw_fin_n1",  s_n1[(a + 2) & 4095],  32'd0);

    // Back-to-back loads of the stored word
    issue(1'b0, F3_B,   32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b0);
    issue(1'b0, F3_BU,  32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 1'b0);
    issue(1'b0, F3_H,   32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1'b0);
    issue(1'b0, F3_HU,  32'h12, 32'h0, 32'h0000DEAD, 1'b0, 2, 1'b0);
    issue(1'b0, F3_W,   32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
    drain();

    // SB uses port1 only
    issue(1'b1, F3_B, 32'h21, 32'h000000AA, 32'h0, 1'b0, 2, 1'b0);
    a = last_acc;
    drain();
    chk("sb_we1",     s_we1[a & 4095], 32'd1);
    chk("sb_n1",      s_n1[a & 4095],  32'h21);
    chk("sb_d1",      s_wd1[a & 4095], 32'hAA);
    chk("sb_we1_fin", s_we1[(a + 1) & 4095], 32'd0);
    chk("sb_we2_ph0", s_we2[a & 4095], 32'd0);
    chk("sb_we2_fin", s_we2[(a + 1) & 4095], 32'd0);
    issue(1'b0, F3_BU, 32'h21, 32'h0, 32'h000000AA, 1'b0, 2, 1'b0);
    issue(1'b1, F3_H,  32'h30, 32'h1234ABCD, 32'h0, 1'b0, 2, 1'b0);
    issue(1'b0, F3_W,  32'h30, 32'h0, 32'h0000ABCD, 1'b0, 3, 1'b0);
    issue(1'b0, F3_H,  32'h30, 32'h0, 32'hFFFFABCD, 1'b0, 2, 1'b0);
    drain();

    // Index wrap at the top of the RAM
    issue(1'b1, F3_B, 32'h7FFF, 32'h11, 32'h0, 1'b0, 2, 1'b0);
    issue(1'b1, F3_B, 32'h0000, 32'h22, 32'h0, 1'b0, 2, 1'b0);
    issue(1'b1, F3_B, 32'h0001, 32'h33, 32'h0, 1'b0, 2, 1'b0);
    issue(1'b1, F3_B, 32'h0002, 32'h44, 32'h0, 1'b0, 2, 1'b0);
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, F3_W, 32'h7FFF, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    a = last_acc;
    drain();
    chk("wrap_flt_we1", s_we1[a & 4095], 32'd0);
    chk("wrap_flt_we2", s_we2[a & 4095], 32'd0);
`else
    issue(1'b0, F3_W, 32'h7FFF, 32'h0, 32'h44332211, 1'b0, 3, 1'b1);
    a = last_acc;
    drain();
    chk("wrap_n1_ph0", s_n1[a & 4095], 32'h7FFF);
    chk("wrap_n2_ph0", s_n2[a & 4095], 32'h0000);
    chk("wrap_n1_ph1", s_n1[(a + 1) & 4095], 32'h0001);
    chk("wrap_n2_ph1", s_n2[(a + 1) & 4095], 32'h0002);
    chk("wrap_we1",    s_we1[a & 4095], 32'd0);
`endif
    repeat (4) @(negedge clk);

    // Misaligned word at 0x102
    issue(1'b1, F3_B, 32'h102, 32'h55, 32'h0, 1'b0, 2, 1'b0);
    issue(1'b1, F3_B, 32'h103, 32'h66, 32'h0, 1'b0, 2, 1'b0);
    issue(1'b1, F3_B, 32'h104, 32'h77, 32'h0, 1'b0, 2, 1'b0);
    issue(1'b1, F3_B, 32'h105, 32'h88, 32'h0, 1'b0, 2, 1'b0);
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, F3_W, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    a = last_acc;
    issue(1'b0, F3_H, 32'h103, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    drain();
    chk("mis_flt_we1", s_we1[a & 4095], 32'd0);
    chk("mis_flt_we2", s_we2[a & 4095], 32'd0);
`else
    issue(1'b0, F3_W, 32'h102, 32'h0, 32'h88776655, 1'b0, 3, 1'b0);
    a = last_acc;
    issue(1'b0, F3_H, 32'h103, 32'h0, 32'h00007766, 1'b0, 2, 1'b0);
    drain();
    chk("mis_n1_ph0", s_n1[a & 4095], 32'h102);
    chk("mis_n2_ph0", s_n2[a & 4095], 32'h103);
    chk("mis_n1_ph1", s_n1[(a + 1) & 4095], 32'h104);
    chk("mis_n2_ph1", s_n2[(a + 1) & 4095], 32'h105);
`endif

    // Asynchronous reset in the middle of a word store
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h60;
    bus.req_wdata  = 32'h11223344;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_ph1_we1", 32'(we1), 32'd1);
    chk("mid_ph1_n1",  n1, 32'h62);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we1",   32'(we1), 32'd0);
    chk("mid_rst_we2",   32'(we2), 32'd0);
    chk("mid_rst_n1",    n1, 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, F3_W, 32'h60, 32'h0, 32'h00003344, 1'b0, 3, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
